// File: rtl/pipe_stage_reg.sv
// Generic Y86-64 inter-stage pipeline register with stall/bubble control,
// fetch-exception folding into stat, optional freeze on exception, and event counters.
module PipeStageRegUnused;
endmodule

module pipe_stage_reg #(
    parameter int         DATA_W          = 128,
    parameter logic [3:0] NOP_ICODE       = 4'h1,
    parameter bit         CLEAR_ON_BUBBLE = 1'b1,
    parameter bit         HOLD_ON_EXC     = 1'b0,
    parameter int         CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_stall,
    input  logic              in_bubble,
    input  logic [3:0]        in_icode,
    input  logic [3:0]        in_ifun,
    input  logic [3:0]        in_stat,
    input  logic [DATA_W-1:0] in_payload,
    input  logic              in_hlt,
    input  logic              in_imem_err,
    input  logic              in_instr_invalid,
    output logic [3:0]        out_icode,
    output logic [3:0]        out_ifun,
    output logic [3:0]        out_stat,
    output logic [DATA_W-1:0] out_payload,
    output logic              out_valid,
    output logic              frozen,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]        icode_q, icode_d;
    logic [3:0]        ifun_q, ifun_d;
    logic [3:0]        stat_q, stat_d;
    logic [DATA_W-1:0] payload_q, payload_d;
    logic              valid_q, valid_d;
    logic              frozen_q, frozen_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0]  bubbleCnt_q, bubbleCnt_d;
    logic [3:0]        encStat;

    // Fetch-side exception flags override the upstream stat, HLT first.
    always_comb begin
        encStat = in_stat;
        if (in_hlt)
            encStat = STAT_HLT;
        else if (in_imem_err)
            encStat = STAT_ADR;
        else if (in_instr_invalid)
            encStat = STAT_INS;
    end

    always_comb begin
        icode_d     = icode_q;
        ifun_d      = ifun_q;
        stat_d      = stat_q;
        payload_d   = payload_q;
        valid_d     = valid_q;
        frozen_d    = frozen_q;
        stallCnt_d  = stallCnt_q;
        bubbleCnt_d = bubbleCnt_q;
        if (frozen_q) begin
            frozen_d = 1'b1;
        end else if (in_stall) begin
            if (stallCnt_q != '1)
                stallCnt_d = stallCnt_q + CNT_ONE;
        end else if (in_bubble) begin
            icode_d = NOP_ICODE;
            ifun_d  = 4'd0;
            stat_d  = STAT_AOK;
            valid_d = 1'b0;
            if (CLEAR_ON_BUBBLE)
                payload_d = '0;
            if (bubbleCnt_q != '1)
                bubbleCnt_d = bubbleCnt_q + CNT_ONE;
        end else begin
            icode_d   = in_icode;
            ifun_d    = in_ifun;
            stat_d    = encStat;
            payload_d = in_payload;
            valid_d   = 1'b1;
            frozen_d  = HOLD_ON_EXC && (encStat != STAT_AOK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            icode_q     <= NOP_ICODE;
            ifun_q      <= 4'd0;
            stat_q      <= STAT_AOK;
            payload_q   <= '0;
            valid_q     <= 1'b0;
            frozen_q    <= 1'b0;
            stallCnt_q  <= '0;
            bubbleCnt_q <= '0;
        end else begin
            icode_q     <= icode_d;
            ifun_q      <= ifun_d;
            stat_q      <= stat_d;
            payload_q   <= payload_d;
            valid_q     <= valid_d;
            frozen_q    <= frozen_d;
            stallCnt_q  <= stallCnt_d;
            bubbleCnt_q <= bubbleCnt_d;
        end
    end

    assign out_icode   = icode_q;
    assign out_ifun    = ifun_q;
    assign out_stat    = stat_q;
    assign out_payload = payload_q;
    assign out_valid   = valid_q;
    assign frozen      = frozen_q;
    assign stall_cnt   = stallCnt_q;
    assign bubble_cnt  = bubbleCnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: instance A uses default parameters, instance B has
// CLEAR_ON_BUBBLE=0, HOLD_ON_EXC=1, CNT_W=4 and a 16-bit payload; both share inputs.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         rst;
    logic         inStall, inBubble;
    logic [3:0]   inIcode, inIfun, inStat;
    logic [127:0] inPayload;
    logic         inHlt, inImemErr, inInstrInvalid;

    logic [3:0]   aIcode, aIfun, aStat;
    logic [127:0] aPayload;
    logic         aValid, aFrozen;
    logic [15:0]  aStallCnt, aBubbleCnt;

    logic [3:0]   bIcode, bIfun, bStat;
    logic [15:0]  bPayload;
    logic         bValid, bFrozen;
    logic [3:0]   bStallCnt, bBubbleCnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dutA (
        .clk(clk), .rst(rst), .in_stall(inStall), .in_bubble(inBubble),
        .in_icode(inIcode), .in_ifun(inIfun), .in_stat(inStat), .in_payload(inPayload),
        .in_hlt(inHlt), .in_imem_err(inImemErr), .in_instr_invalid(inInstrInvalid),
        .out_icode(aIcode), .out_ifun(aIfun), .out_stat(aStat), .out_payload(aPayload),
        .out_valid(aValid), .frozen(aFrozen), .stall_cnt(aStallCnt), .bubble_cnt(aBubbleCnt)
    );

    pipe_stage_reg #(.DATA_W(16), .CLEAR_ON_BUBBLE(1'b0), .HOLD_ON_EXC(1'b1), .CNT_W(4)) dutB (
        .clk(clk), .rst(rst), .in_stall(inStall), .in_bubble(inBubble),
        .in_icode(inIcode), .in_ifun(inIfun), .in_stat(inStat), .in_payload(inPayload[15:0]),
        .in_hlt(inHlt), .in_imem_err(inImemErr), .in_instr_invalid(inInstrInvalid),
        .out_icode(bIcode), .out_ifun(bIfun), .out_stat(bStat), .out_payload(bPayload),
        .out_valid(bValid), .frozen(bFrozen), .stall_cnt(bStallCnt), .bubble_cnt(bBubbleCnt)
    );

    // Drive one cycle's worth of inputs, clock it in, then sample just after the edge.
    task automatic applyStimulus(input logic r, input logic st, input logic bu,
                                 input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] sa,
                                 input logic [127:0] pl, input logic [2:0] flags, input int cycles);
        rst = r; inStall = st; inBubble = bu;
        inIcode = ic; inIfun = fn; inStat = sa; inPayload = pl;
        {inHlt, inImemErr, inInstrInvalid} = flags;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        applyStimulus(1, 0, 0, 4'h0, 4'h0, 4'h1, 128'h0, 3'b000, 2);
        checkOutput("rstAIcode", aIcode, 4'h1);
        checkOutput("rstAValid", aValid, 1'b0);
        checkOutput("rstAStat", aStat, 4'h1);
        checkOutput("rstAPayload", aPayload, 128'h0);
        checkOutput("rstBFrozen", bFrozen, 1'b0);
        checkOutput("rstBCnt", {bStallCnt, bBubbleCnt}, 8'h00);

        applyStimulus(0, 0, 0, 4'h6, 4'h1, 4'h1, 128'hABCD, 3'b000, 1);
        checkOutput("loadAIcode", aIcode, 4'h6);
        checkOutput("loadAIfun", aIfun, 4'h1);
        checkOutput("loadAStat", aStat, 4'h1);
        checkOutput("loadAPayload", aPayload, 128'hABCD);
        checkOutput("loadAValid", aValid, 1'b1);
        checkOutput("loadBPayload", bPayload, 16'hABCD);

        applyStimulus(0, 1, 1, 4'h2, 4'h3, 4'h1, 128'h5555, 3'b100, 3);
        checkOutput("stallAFields", {aIcode, aIfun, aStat, aValid}, {4'h6, 4'h1, 4'h1, 1'b1});
        checkOutput("stallAPayload", aPayload, 128'hABCD);
        checkOutput("stallACnt", aStallCnt, 16'd3);
        checkOutput("stallABub", aBubbleCnt, 16'd0);
        checkOutput("stallBCnt", bStallCnt, 4'd3);

        applyStimulus(0, 0, 1, 4'h2, 4'h3, 4'h4, 128'h5555, 3'b010, 1);
        checkOutput("bubAFields", {aIcode, aIfun, aStat, aValid}, {4'h1, 4'h0, 4'h1, 1'b0});
        checkOutput("bubAPayload", aPayload, 128'h0);
        checkOutput("bubABub", aBubbleCnt, 16'd1);
        checkOutput("bubBFields", {bIcode, bIfun, bStat, bValid}, {4'h1, 4'h0, 4'h1, 1'b0});
        checkOutput("bubBPayload", bPayload, 16'hABCD);
        checkOutput("bubBBub", bBubbleCnt, 4'd1);

        applyStimulus(0, 0, 0, 4'h3, 4'h0, 4'h1, 128'h1111, 3'b111, 1);
        checkOutput("prioAHlt", aStat, 4'h2);
        checkOutput("prioAIcode", aIcode, 4'h3);
        checkOutput("prioAFrozen", aFrozen, 1'b0);
        checkOutput("excBFrozen", bFrozen, 1'b1);
        checkOutput("excBStat", bStat, 4'h2);

        applyStimulus(0, 0, 0, 4'h4, 4'h0, 4'h1, 128'h1112, 3'b011, 1);
        checkOutput("prioAAdr", aStat, 4'h3);
        checkOutput("frzBIcode", bIcode, 4'h3);
        checkOutput("frzBStat", bStat, 4'h2);

        applyStimulus(0, 0, 0, 4'h5, 4'h0, 4'h1, 128'h1113, 3'b001, 1);
        checkOutput("prioAIns", aStat, 4'h4);

        applyStimulus(0, 0, 0, 4'h6, 4'h0, 4'h1, 128'h1114, 3'b000, 1);
        checkOutput("prioAAok", aStat, 4'h1);
        checkOutput("frzBPayload", bPayload, 16'h1111);

        applyStimulus(1, 1, 0, 4'h6, 4'h0, 4'h1, 128'h0, 3'b000, 1);
        checkOutput("rstBUnfreeze", bFrozen, 1'b0);
        checkOutput("rstBIcode", bIcode, 4'h1);

        applyStimulus(0, 0, 0, 4'h5, 4'h2, 4'h1, 128'h2222, 3'b010, 1);
        checkOutput("exc2BFrozen", bFrozen, 1'b1);
        checkOutput("exc2BStat", bStat, 4'h3);
        checkOutput("exc2BValid", bValid, 1'b1);

        applyStimulus(0, 0, 0, 4'h7, 4'h0, 4'h1, 128'h3333, 3'b000, 1);
        applyStimulus(0, 1, 0, 4'h7, 4'h0, 4'h1, 128'h3333, 3'b000, 1);
        applyStimulus(0, 0, 1, 4'h7, 4'h0, 4'h1, 128'h3333, 3'b000, 1);
        applyStimulus(0, 1, 0, 4'h7, 4'h0, 4'h1, 128'h3333, 3'b000, 1);
        applyStimulus(0, 0, 0, 4'h7, 4'h0, 4'h1, 128'h3333, 3'b000, 1);
        checkOutput("holdBFields", {bIcode, bIfun, bStat, bValid, bFrozen}, {4'h5, 4'h2, 4'h3, 1'b1, 1'b1});
        checkOutput("holdBPayload", bPayload, 16'h2222);
        checkOutput("holdBCnt", {bStallCnt, bBubbleCnt}, 8'h00);
        checkOutput("seqAFields", {aIcode, aStat, aValid}, {4'h7, 4'h1, 1'b1});
        checkOutput("seqACnt", {aStallCnt, aBubbleCnt}, {16'd2, 16'd1});

        applyStimulus(1, 0, 0, 4'h0, 4'h0, 4'h1, 128'h0, 3'b000, 1);
        checkOutput("rst3BFrozen", bFrozen, 1'b0);

        applyStimulus(0, 1, 0, 4'h0, 4'h0, 4'h1, 128'h0, 3'b000, 20);
        checkOutput("satBStall", bStallCnt, 4'd15);
        checkOutput("satAStall", aStallCnt, 16'd20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
